// File: rtl/simon_sequence_store.sv
// Colour-sequence memory for the Simon Says core: appends colours, replays them over a
// valid/ready stream, and checks player guesses against them one handshake at a time.
module simon_sequence_store #(
    parameter int unsigned COLOUR_W = 2,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned LEN_W    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear_i,
    input  logic                append_valid_i,
    input  logic [COLOUR_W-1:0] append_colour_i,
    output logic                append_ready_o,
    input  logic                play_start_i,
    input  logic                check_start_i,
    input  logic                abort_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [COLOUR_W-1:0] out_colour_o,
    output logic                out_last_o,
    input  logic                guess_valid_i,
    input  logic [COLOUR_W-1:0] guess_colour_i,
    output logic                guess_ready_o,
    output logic [LEN_W-1:0]    length_o,
    output logic                full_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                pass_o,
    output logic                fail_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StPlay, StCheck} state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [LEN_W-1:0]    length_q, length_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                fail_q, fail_d;
    logic                wr_en;
    logic                is_full;
    logic                at_last;
    logic [COLOUR_W-1:0] rd_colour;
    logic [COLOUR_W-1:0] mem [DEPTH];

    assign is_full   = (length_q == LEN_W'(DEPTH));
    assign at_last   = (LEN_W'(ptr_q) == (length_q - LEN_W'(1)));
    assign rd_colour = mem[ptr_q];

    // State and control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            length_q <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            length_q <= length_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
        end
    end

    // Storage is deliberately not cleared; only length bounds what is valid.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[length_q[PTR_W-1:0]] <= append_colour_i;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        length_d = length_q;
        done_d   = 1'b0;
        pass_d   = 1'b0;
        fail_d   = 1'b0;
        wr_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clear_i) begin
                    length_d = '0;
                end else begin
                    if (append_valid_i && !is_full) begin
                        wr_en    = 1'b1;
                        length_d = length_q + LEN_W'(1);
                    end
                    // Start qualifies on the sampled length; a same-cycle append still
                    // lands before the first read.
                    if (length_q != '0) begin
                        if (play_start_i) begin
                            state_d = StPlay;
                            ptr_d   = '0;
                        end else if (check_start_i) begin
                            state_d = StCheck;
                            ptr_d   = '0;
                        end
                    end
                end
            end
            StPlay: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (out_ready_i) begin
                    if (at_last) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                end
            end
            StCheck: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (guess_valid_i) begin
                    if (guess_colour_i != rd_colour) begin
                        state_d = StIdle;
                        fail_d  = 1'b1;
                    end else if (at_last) begin
                        state_d = StIdle;
                        pass_d  = 1'b1;
                    end else begin
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_valid_o    = (state_q == StPlay);
        out_colour_o   = out_valid_o ? rd_colour : '0;
        out_last_o     = out_valid_o && at_last;
        guess_ready_o  = (state_q == StCheck);
        busy_o         = (state_q != StIdle);
        append_ready_o = (state_q == StIdle) && !is_full;
        length_o       = length_q;
        full_o         = is_full;
        done_o         = done_q;
        pass_o         = pass_q;
        fail_o         = fail_q;
    end

endmodule

// File: tb/tb_simon_sequence_store.sv
// Directed bench for simon_sequence_store: append, replay, stalls, checking, full,
// abort, reset and start arbitration.
module tb_simon_sequence_store;

    localparam int unsigned D  = 8;
    localparam int unsigned LW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          clear, av, ps, cs, abort, ordy, gv;
    logic [1:0]    ac, gc;
    logic          aready, ovalid, olast, gready, full, busy, done, pass, fail;
    logic [1:0]    ocol;
    logic [LW-1:0] len;

    int n_cmp = 0;
    int n_err = 0;

    simon_sequence_store #(.COLOUR_W(2), .DEPTH(D)) dut (
        .clk            (clk),
        .reset          (reset),
        .clear_i        (clear),
        .append_valid_i (av),
        .append_colour_i(ac),
        .append_ready_o (aready),
        .play_start_i   (ps),
        .check_start_i  (cs),
        .abort_i        (abort),
        .out_valid_o    (ovalid),
        .out_ready_i    (ordy),
        .out_colour_o   (ocol),
        .out_last_o     (olast),
        .guess_valid_i  (gv),
        .guess_colour_i (gc),
        .guess_ready_o  (gready),
        .length_o       (len),
        .full_o         (full),
        .busy_o         (busy),
        .done_o         (done),
        .pass_o         (pass),
        .fail_o         (fail)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic app(input logic [1:0] c);
        av = 1'b1;
        ac = c;
        tick();
        av = 1'b0;
    endtask

    logic [1:0] seq4 [4];
    logic [1:0] seqd [D];
    logic [1:0] bad3 [3];

    initial begin
        int idx;
        seq4 = '{2'd2, 2'd0, 2'd3, 2'd1};
        bad3 = '{2'd2, 2'd0, 2'd1};
        for (int i = 0; i < D; i++) seqd[i] = 2'((i * 3 + 1) % 4);

        reset = 1'b1; clear = 0; av = 0; ac = 0; ps = 0; cs = 0; abort = 0;
        ordy = 0; gv = 0; gc = 0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_aready", aready, 1);
        chk("rst_len", len, 0);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovalid", ovalid, 0);
        chk("rst_ocol", ocol, 0);
        chk("rst_gready", gready, 0);
        chk("rst_pulses", {done, pass, fail}, 0);

        // Basic append and full-rate replay
        for (int i = 0; i < 4; i++) app(seq4[i]);
        chk("app_len", len, 4);
        ps = 1; ordy = 1;
        tick();
        ps = 0;
        for (int i = 0; i < 4; i++) begin
            chk("play_valid", ovalid, 1);
            chk("play_col", ocol, seq4[i]);
            chk("play_last", olast, (i == 3) ? 1 : 0);
            chk("play_len", len, 4);
            chk("play_done_early", done, 0);
            tick();
        end
        chk("play_done", done, 1);
        chk("play_busy_at_done", busy, 0);
        chk("play_ovalid_after", ovalid, 0);
        tick();
        chk("play_done_once", done, 0);

        // Replay with stalls: out_ready pattern 1,0,0,1,0,0,...
        ps = 1;
        tick();
        ps = 0;
        idx = 0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            ordy = (c % 3 == 0);
            chk("stall_col", ocol, seq4[idx]);
            chk("stall_valid", ovalid, 1);
            tick();
            if (ordy) idx++;
        end
        ordy = 0;
        chk("stall_count", idx, 4);
        chk("stall_done", done, 1);

        // Check: correct guesses
        tick();
        cs = 1;
        tick();
        cs = 0;
        for (int i = 0; i < 4; i++) begin
            gv = 1; gc = seq4[i];
            chk("chk_gready", gready, 1);
            chk("chk_nopulse", {pass, fail}, 0);
            tick();
        end
        gv = 0;
        chk("chk_pass", pass, 1);
        chk("chk_nofail", fail, 0);
        chk("chk_busy", busy, 0);
        tick();
        chk("chk_pass_once", pass, 0);

        // Check: third guess wrong, fourth ignored
        cs = 1;
        tick();
        cs = 0;
        for (int i = 0; i < 3; i++) begin
            gv = 1; gc = bad3[i];
            chk("bad_nofail_early", fail, 0);
            tick();
        end
        chk("bad_fail", fail, 1);
        chk("bad_nopass", pass, 0);
        chk("bad_gready", gready, 0);
        gc = 2'd1;
        tick();
        gv = 0;
        chk("bad_fail_once", fail, 0);
        chk("bad_ignored", {pass, busy}, 0);
        chk("bad_len", len, 4);

        // Fill to DEPTH plus one dropped append
        clear = 1;
        tick();
        clear = 0;
        chk("clr_len", len, 0);
        for (int i = 0; i < D; i++) app(seqd[i]);
        chk("full_flag", full, 1);
        chk("full_aready", aready, 0);
        chk("full_len", len, D);
        app(2'd3);
        chk("full_len_sat", len, D);
        chk("full_flag2", full, 1);
        ps = 1; ordy = 1;
        tick();
        ps = 0;
        for (int i = 0; i < D; i++) begin
            chk("full_col", ocol, seqd[i]);
            chk("full_last", olast, (i == D - 1) ? 1 : 0);
            tick();
        end
        chk("full_done", done, 1);

        // Abort mid-replay at entry 2
        tick();
        ps = 1;
        tick();
        ps = 0;
        tick(); tick();
        chk("abort_at2", ocol, seqd[2]);
        abort = 1; ordy = 0;
        tick();
        abort = 0;
        chk("abort_busy", busy, 0);
        chk("abort_ovalid", ovalid, 0);
        chk("abort_pulses", {done, pass, fail}, 0);
        chk("abort_len", len, D);
        tick();
        chk("abort_pulses2", {done, pass, fail}, 0);

        // Reset mid-check
        cs = 1;
        tick();
        cs = 0;
        gv = 1; gc = seqd[0];
        tick();
        gv = 0;
        chk("rmid_busy_before", busy, 1);
        reset = 1;
        tick();
        reset = 0;
        chk("rmid_busy", busy, 0);
        chk("rmid_gready", gready, 0);
        chk("rmid_len", len, 0);
        chk("rmid_aready", aready, 1);
        chk("rmid_pulses", {done, pass, fail}, 0);
        tick();
        chk("rmid_pulses2", {done, pass, fail}, 0);

        // Arbitration: play wins over check
        app(2'd3);
        ps = 1; cs = 1; ordy = 0;
        tick();
        ps = 0; cs = 0;
        chk("arb_play", ovalid, 1);
        chk("arb_nocheck", gready, 0);
        abort = 1;
        tick();
        abort = 0;
        clear = 1;
        tick();
        clear = 0;
        ps = 1;
        tick();
        ps = 0;
        chk("zero_start_busy", busy, 0);
        tick();
        chk("zero_start_pulses", {done, pass, fail}, 0);

        // Append in the start cycle joins the replay
        app(2'd3);
        av = 1; ac = 2'd2; ps = 1; ordy = 1;
        tick();
        av = 0; ps = 0;
        chk("cat_len", len, 2);
        chk("cat_col0", ocol, 3);
        chk("cat_last0", olast, 0);
        tick();
        chk("cat_col1", ocol, 2);
        chk("cat_last1", olast, 1);
        tick();
        chk("cat_done", done, 1);
        ordy = 0;

        // Clear outranks a same-cycle append and start
        clear = 1; av = 1; ac = 2'd1; ps = 1;
        tick();
        clear = 0; av = 0; ps = 0;
        chk("clr_prio_len", len, 0);
        chk("clr_prio_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/simon_sequence_store.md
# simon_sequence_store

Parametrised colour-sequence memory for the Simon Says core, and the successor to the fixed 32-entry shift-array. It stores the game's colour sequence oldest-first. It can replay that sequence over a valid/ready stream to the LED/tone driver. It can also check a player's guesses against the sequence, one per handshake, and report pass/fail to the game FSM. Append, replay and check are mutually exclusive, arbitrated by an internal state machine.

## Interface
Parameters:
- COLOUR_W, 2, bits per colour code
- DEPTH, 32, maximum sequence length (≥2)
- LEN_W, $clog2(DEPTH+1), width of length count

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- clear  in  1  empty the sequence (length←0); honoured in IDLE only
- append_valid  in  1  request to append append_colour at the end of the sequence
- append_colour  in  COLOUR_W  colour to append
- append_ready  out  1  high when state==IDLE and !full
- play_start  in  1  begin replay (IDLE only)
- check_start  in  1  begin guess checking (IDLE only)
- abort  in  1  return to IDLE from PLAY/CHECK, no result pulse
- out_valid  out  1  replay colour valid (PLAY)
- out_ready  in  1  consumer accepts out_colour
- out_colour  out  COLOUR_W  sequence entry at read pointer; 0 when !out_valid
- out_last  out  1  out_valid and pointer==length-1
- guess_valid  in  1  player guess present
- guess_colour  in  COLOUR_W  guessed colour
- guess_ready  out  1  high in CHECK
- length  out  LEN_W  number of stored colours
- full  out  1  length==DEPTH
- busy  out  1  state!=IDLE
- done  out  1  one-cycle pulse at the end of a replay
- pass  out  1  one-cycle pulse when the full sequence is matched
- fail  out  1  one-cycle pulse on the first mismatch

## Operation
- Storage: mem[0..DEPTH-1], where mem[0] is the oldest entry. An append writes mem[length] and then increments length. Memory is not cleared on reset or clear; only length is reset.
- States: IDLE, PLAY, CHECK. A registered pointer ptr (width $clog2(DEPTH)) is used for both PLAY and CHECK.
- IDLE, evaluated in this priority order per cycle:
  - clear: sets length←0. No other action occurs that cycle; append and start are ignored.
  - append_valid && append_ready: performs the write and length+1.
  - Append in the same cycle as a start is allowed. The appended entry is part of the started pass.
  - play_start with the sampled length≠0: ptr←0, go to PLAY.
  - check_start with the sampled length≠0: ptr←0, go to CHECK. play_start wins if both are asserted.
  - A start with length==0 is ignored and produces no pulses.
- PLAY:
  - out_valid=1 and out_colour=mem[ptr].
  - On out_valid&&out_ready: if out_last, go to IDLE and pulse done next cycle; otherwise ptr+1.
  - out_colour is held stable while out_ready is low.
- CHECK:
  - On guess_valid&&guess_ready, compare guess_colour with mem[ptr].
  - Mismatch: go to IDLE, pulse fail.
  - Match with ptr==length-1: go to IDLE, pulse pass.
  - Otherwise: ptr+1.
- abort in PLAY/CHECK: go to IDLE next cycle. No done/pass/fail pulse; length unchanged. abort in IDLE has no effect.
- Full: append_valid while full is dropped silently; length saturates at DEPTH.
- Inputs that do not apply to the current state are ignored: append/clear/start in PLAY or CHECK, guess_valid outside CHECK, out_ready outside PLAY.
- Reset: state IDLE, length 0, ptr 0. Every output is 0 except append_ready=1. full=0, busy=0, done/pass/fail=0.
- Reset asserted mid-PLAY or mid-CHECK takes effect at the next edge and produces no result pulse.

## Timing
- Append: the edge where append_valid&&append_ready is sampled writes the entry. length/full update that edge and are visible the next cycle.
- Start: on the start edge the state changes. out_valid (or guess_ready) goes high in the cycle immediately after, with out_colour=mem[0]. Zero bubble.
- Replay throughput is one entry per cycle while out_ready=1. A sequence of N entries needs N accepted handshakes.
- done/pass/fail are registered and asserted exactly one cycle after the final handshake edge. busy is 0 in that same cycle.
- A new start can be accepted in the cycle done/pass/fail is high.
- out_colour, out_valid, out_last and guess_ready are decoded from registered state/ptr only. There is no combinational path from inputs to outputs except append_ready, which depends only on state and full.

## Test plan
- After reset, append 2,0,3,1, then assert play_start with out_ready=1. Required: out_colour 2,0,3,1 on consecutive cycles, out_last on the 4th entry, done one cycle later, length=4 throughout.
- Replay with out_ready toggling 1,0,0,1,… Required: each colour is held during stalls and the sequence is unchanged.
- Check the stored 2,0,3,1 with guesses 2,0,3,1. Required: pass pulses once, fail never. Repeat with guesses 2,0,1. Required: fail one cycle after the 3rd guess, and the 4th guess is ignored because guess_ready=0.
- Perform DEPTH appends, then one extra append. Required: full=1, append_ready=0, length=DEPTH. Replay then returns all DEPTH entries in order.
- Apply abort mid-replay at entry 2, then apply reset mid-check. Required: no done/pass/fail pulses; after abort length is unchanged, after reset length=0 and the state is IDLE.
- Assert play_start and check_start together, then play_start at length 0, then append in the same cycle as play_start at length 1. Required: PLAY is selected; the zero-length start is ignored; the replay covers 2 entries.
